// File: rtl/xsw_rsp_router_pkg.sv
// Shared types and helpers for the crossbar response router.
package xsw_rsp_router_pkg;

  function automatic int unsigned xsw_idw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic int unsigned xsw_oh2idx(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int k = 31; k >= 0; k--) begin
      if (vec[k]) idx = 32'(k);
    end
    return idx;
  endfunction

  localparam int unsigned XSW_N_DEF = 2;
  typedef logic [xsw_idw(XSW_N_DEF)-1:0] xsw_id_t;

endpackage

// File: rtl/xsw_rsp_router_if.sv
// Forward-switch snoop and response handshake bundle for the response router.
interface xsw_rsp_router_if #(
  parameter int unsigned N  = 2,
  parameter int unsigned M  = 2,
  parameter int unsigned DW = 8
);
  logic [M-1:0]    fwd_vld;
  logic [M-1:0]    fwd_gnt;
  logic [M*N-1:0]  fwd_src;
  logic [M-1:0]    fwd_stall;
  logic [M-1:0]    rsp_vld_i;
  logic [M*DW-1:0] rsp_dat_i;
  logic [M-1:0]    rsp_gnt_i;
  logic [N-1:0]    rsp_vld_o;
  logic [N*DW-1:0] rsp_dat_o;
  logic [N-1:0]    rsp_gnt_o;

  modport slave (
    input  fwd_vld, fwd_gnt, fwd_src, rsp_vld_i, rsp_dat_i, rsp_gnt_o,
    output fwd_stall, rsp_gnt_i, rsp_vld_o, rsp_dat_o
  );

  modport master (
    output fwd_vld, fwd_gnt, fwd_src, rsp_vld_i, rsp_dat_i, rsp_gnt_o,
    input  fwd_stall, rsp_gnt_i, rsp_vld_o, rsp_dat_o
  );
endinterface

// File: rtl/xsw_rsp_router_id_fifo.sv
// In-order FIFO of originating-initiator IDs for one target; head valid when not empty.
module xsw_rsp_router_id_fifo #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + PW'(1);
    if (pop_i)  rd_d = rd_q + PW'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; the count gates what is visible.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) push_i |-> !full_o);
`endif

endmodule

// File: rtl/xsw_rsp_router.sv
// Crossbar return path: tags accepted requests per target, routes responses back by round-robin.
module xsw_rsp_router
  import xsw_rsp_router_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned M     = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  xsw_rsp_router_if.slave    bus,
  output logic               err_o
);
  localparam int unsigned IW = xsw_idw(N);
  localparam int unsigned MW = xsw_idw(M);

  logic [M-1:0]          full, empty, push, pop, stray, bad_src;
  logic [IW-1:0]         push_id [M];
  logic [IW-1:0]         head_id [M];
  logic [N-1:0][M-1:0]   win_all;
  logic [M-1:0]          win_any;
  logic                  err_q, err_d;

  for (genvar t = 0; t < M; t++) begin : g_tgt
    logic [N-1:0] src;
    assign src          = bus.fwd_src[t*N +: N];
    assign push[t]      = ~rst & bus.fwd_vld[t] & bus.fwd_gnt[t] & ~full[t];
    assign push_id[t]   = IW'(xsw_oh2idx(32'(src)));
    assign bad_src[t]   = push[t] & ~$onehot(src);
    // A response with no outstanding ID is swallowed so the target never hangs.
    assign stray[t]     = ~rst & bus.rsp_vld_i[t] & empty[t];
    assign pop[t]       = bus.rsp_vld_i[t] & bus.rsp_gnt_i[t] & ~empty[t];
    assign bus.fwd_stall[t] = ~rst & full[t];

    xsw_rsp_router_id_fifo #(.W(IW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push[t]),
      .pop_i  (pop[t]),
      .din_i  (push_id[t]),
      .full_o (full[t]),
      .empty_o(empty[t]),
      .head_o (head_id[t])
    );
  end

  for (genvar i = 0; i < N; i++) begin : g_ini
    logic [M-1:0]  req, win;
    logic [MW-1:0] ptr_q, ptr_d, widx;
    logic [DW-1:0] dat;
    logic          found;

    // Round-robin search starting at ptr_q; pointer advances only on a completed transfer.
    always_comb begin
      int unsigned idx;
      idx   = 0;
      req   = '0;
      win   = '0;
      widx  = '0;
      dat   = '0;
      found = 1'b0;
      ptr_d = ptr_q;
      for (int t = 0; t < M; t++) begin
        req[t] = ~rst & bus.rsp_vld_i[t] & ~empty[t] & (head_id[t] == IW'(i));
      end
      for (int k = 0; k < M; k++) begin
        idx = (32'(ptr_q) + 32'(k)) % M;
        for (int t = 0; t < M; t++) begin
          if (!found && req[t] && (32'(t) == idx)) begin
            found  = 1'b1;
            widx   = MW'(t);
            win[t] = 1'b1;
            dat    = bus.rsp_dat_i[DW*t +: DW];
          end
        end
      end
      if (found && bus.rsp_gnt_o[i]) begin
        ptr_d = (32'(widx) == M - 1) ? '0 : widx + MW'(1);
      end
    end

    assign win_all[i]               = win;
    assign bus.rsp_vld_o[i]         = |req;
    assign bus.rsp_dat_o[DW*i +: DW] = dat;

    always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
    end

`ifndef SYNTHESIS
    a_win_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(win));
`endif
  end

  always_comb begin
    win_any       = '0;
    bus.rsp_gnt_i = '0;
    for (int t = 0; t < M; t++) begin
      for (int i = 0; i < N; i++) begin
        win_any[t] = win_any[t] | win_all[i][t];
      end
      bus.rsp_gnt_i[t] = stray[t] | (win_any[t] & bus.rsp_gnt_o[head_id[t]]);
    end
  end

  assign err_d = err_q | (|stray) | (|bad_src);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_xsw_rsp_router.sv
// Directed bench for xsw_rsp_router with a scoreboard monitor on the initiator side.
module tb_xsw_rsp_router;
  localparam int unsigned N = 2, M = 2, DW = 8, DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic err_o;

  always #5 clk = ~clk;

  xsw_rsp_router_if #(.N(N), .M(M), .DW(DW)) bus ();

  xsw_rsp_router #(.N(N), .M(M), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .err_o(err_o)
  );

  logic [DW-1:0] exp0[$];
  logic [DW-1:0] exp1[$];
  logic [DW-1:0] mon_got, mon_want;
  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_rsp(input int ini, input logic [DW-1:0] d);
    if (ini == 0) exp0.push_back(d);
    else          exp1.push_back(d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Scoreboard: every initiator-side transfer must match the oldest expected response.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (bus.rsp_vld_o[i] && bus.rsp_gnt_o[i]) begin
          mon_got = bus.rsp_dat_o[DW*i +: DW];
          checks++;
          if ((i == 0 && exp0.size() == 0) || (i == 1 && exp1.size() == 0)) begin
            $display("FAIL rsp_ini%0d: got %0h expected no response", i, mon_got);
          end else begin
            if (i == 0) mon_want = exp0.pop_front();
            else        mon_want = exp1.pop_front();
            if (mon_got === mon_want) passes++;
            else $display("FAIL rsp_ini%0d: got %0h expected %0h", i, mon_got, mon_want);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.fwd_vld   = '0;
    bus.fwd_gnt   = '0;
    bus.fwd_src   = '0;
    bus.rsp_vld_i = '0;
    bus.rsp_dat_i = '0;
    bus.rsp_gnt_o = 2'b11;
    step();
    step();
    settle();
    chk("rst_stall", 32'(bus.fwd_stall), 32'h0);
    chk("rst_vld_o", 32'(bus.rsp_vld_o), 32'h0);
    chk("rst_gnt_i", 32'(bus.rsp_gnt_i), 32'h0);
    chk("rst_dat_o", 32'(bus.rsp_dat_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    rst = 1'b0;

    // 1: single response routed to initiator 1
    bus.fwd_vld = 2'b01; bus.fwd_gnt = 2'b01; bus.fwd_src = 4'b0010;
    step();
    bus.fwd_vld = '0; bus.fwd_gnt = '0; bus.fwd_src = '0;
    bus.rsp_vld_i = 2'b01; bus.rsp_dat_i = 16'h00A5;
    expect_rsp(1, 8'hA5);
    settle();
    chk("t1_vld_o", 32'(bus.rsp_vld_o), 32'h2);
    chk("t1_gnt_i", 32'(bus.rsp_gnt_i), 32'h1);
    step();
    bus.rsp_vld_i = '0;
    settle();
    chk("t1_idle", 32'(bus.rsp_vld_o), 32'h0);

    // 2: fill target 1, stall, pop with blocked push
    bus.fwd_vld = 2'b10; bus.fwd_gnt = 2'b10; bus.fwd_src = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t2_stall_%0d", k), 32'(bus.fwd_stall), (k == 3) ? 32'h2 : 32'h0);
    end
    bus.rsp_vld_i = 2'b10; bus.rsp_dat_i = 16'h1100;
    expect_rsp(0, 8'h11);
    settle();
    chk("t2_stall_pop", 32'(bus.fwd_stall), 32'h2);
    chk("t2_gnt_pop", 32'(bus.rsp_gnt_i), 32'h2);
    step();
    chk("t2_stall_clr", 32'(bus.fwd_stall), 32'h0);
    bus.rsp_dat_i = 16'h1200;
    expect_rsp(0, 8'h12);
    step();
    chk("t2_stall_pp", 32'(bus.fwd_stall), 32'h0);
    bus.rsp_vld_i = '0;
    step();
    chk("t2_stall_refill", 32'(bus.fwd_stall), 32'h2);
    bus.fwd_vld = '0; bus.fwd_gnt = '0; bus.fwd_src = '0;
    bus.rsp_vld_i = 2'b10;
    for (int k = 0; k < 4; k++) begin
      bus.rsp_dat_i = 16'(DW'(8'h13 + k)) << 8;
      expect_rsp(0, DW'(8'h13 + k));
      step();
    end
    bus.rsp_vld_i = '0;
    settle();
    chk("t2_drained_stall", 32'(bus.fwd_stall), 32'h0);
    chk("t2_drained_vld", 32'(bus.rsp_vld_o), 32'h0);

    // 3: round-robin between targets for initiator 0, winner held while stalled
    bus.fwd_vld = 2'b11; bus.fwd_gnt = 2'b11; bus.fwd_src = 4'b0101;
    step();
    step();
    bus.fwd_vld = '0; bus.fwd_gnt = '0; bus.fwd_src = '0;
    bus.rsp_gnt_o = 2'b00;
    bus.rsp_vld_i = 2'b11; bus.rsp_dat_i = 16'hB0A0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("t3_hold_vld", 32'(bus.rsp_vld_o), 32'h1);
      chk("t3_hold_gnt", 32'(bus.rsp_gnt_i), 32'h0);
      chk("t3_hold_dat", 32'(bus.rsp_dat_o[7:0]), 32'hA0);
      step();
    end
    bus.rsp_gnt_o = 2'b01;
    expect_rsp(0, 8'hA0); settle(); chk("t3_win0", 32'(bus.rsp_gnt_i), 32'h1); step();
    bus.rsp_dat_i = 16'hB0A1;
    expect_rsp(0, 8'hB0); settle(); chk("t3_win1", 32'(bus.rsp_gnt_i), 32'h2); step();
    bus.rsp_dat_i = 16'hB1A1;
    expect_rsp(0, 8'hA1); settle(); chk("t3_win2", 32'(bus.rsp_gnt_i), 32'h1); step();
    bus.rsp_vld_i = 2'b10; bus.rsp_dat_i = 16'hB100;
    expect_rsp(0, 8'hB1); settle(); chk("t3_win3", 32'(bus.rsp_gnt_i), 32'h2); step();
    bus.rsp_vld_i = '0;
    bus.rsp_gnt_o = 2'b11;

    // 4: stray response is swallowed and flagged
    bus.rsp_vld_i = 2'b10; bus.rsp_dat_i = 16'h7700;
    settle();
    chk("t4_gnt_i", 32'(bus.rsp_gnt_i), 32'h2);
    chk("t4_vld_o", 32'(bus.rsp_vld_o), 32'h0);
    chk("t4_err_pre", 32'(err_o), 32'h0);
    step();
    bus.rsp_vld_i = '0;
    chk("t4_err_set", 32'(err_o), 32'h1);
    step();
    chk("t4_err_sticky", 32'(err_o), 32'h1);
    do_reset();
    chk("t4_err_rst", 32'(err_o), 32'h0);

    // 5: mixed IDs on one target keep order per initiator
    bus.fwd_vld = 2'b01; bus.fwd_gnt = 2'b01;
    bus.fwd_src = 4'b0001; step();
    bus.fwd_src = 4'b0010; step();
    bus.fwd_src = 4'b0001; step();
    bus.fwd_vld = '0; bus.fwd_gnt = '0; bus.fwd_src = '0;
    bus.rsp_vld_i = 2'b01;
    bus.rsp_dat_i = 16'h0010; expect_rsp(0, 8'h10); settle(); chk("t5_vld0", 32'(bus.rsp_vld_o), 32'h1); step();
    bus.rsp_dat_i = 16'h0021; expect_rsp(1, 8'h21); settle(); chk("t5_vld1", 32'(bus.rsp_vld_o), 32'h2); step();
    bus.rsp_dat_i = 16'h0032; expect_rsp(0, 8'h32); settle(); chk("t5_vld2", 32'(bus.rsp_vld_o), 32'h1); step();
    bus.rsp_vld_i = '0;

    // 6: reset discards outstanding IDs
    bus.fwd_vld = 2'b10; bus.fwd_gnt = 2'b10; bus.fwd_src = 4'b0100;
    step(); step(); step();
    bus.fwd_vld = '0; bus.fwd_gnt = '0; bus.fwd_src = '0;
    rst = 1'b1;
    bus.rsp_vld_i = 2'b10; bus.rsp_dat_i = 16'h5500;
    settle();
    chk("t6_rst_vld", 32'(bus.rsp_vld_o), 32'h0);
    chk("t6_rst_gnt", 32'(bus.rsp_gnt_i), 32'h0);
    step();
    rst = 1'b0;
    settle();
    chk("t6_stall", 32'(bus.fwd_stall), 32'h0);
    chk("t6_err_clr", 32'(err_o), 32'h0);
    chk("t6_stray_gnt", 32'(bus.rsp_gnt_i), 32'h2);
    chk("t6_stray_vld", 32'(bus.rsp_vld_o), 32'h0);
    step();
    bus.rsp_vld_i = '0;
    chk("t6_err_set", 32'(err_o), 32'h1);

    // 7: non-one-hot source flags error and pushes lowest set bit
    do_reset();
    bus.fwd_vld = 2'b01; bus.fwd_gnt = 2'b01; bus.fwd_src = 4'b0011;
    step();
    bus.fwd_vld = '0; bus.fwd_gnt = '0; bus.fwd_src = '0;
    chk("t7_err", 32'(err_o), 32'h1);
    bus.rsp_vld_i = 2'b01; bus.rsp_dat_i = 16'h00C3;
    expect_rsp(0, 8'hC3);
    settle();
    chk("t7_vld", 32'(bus.rsp_vld_o), 32'h1);
    step();
    bus.rsp_vld_i = '0;

    step();
    step();
    chk("sb_empty0", 32'(exp0.size()), 32'h0);
    chk("sb_empty1", 32'(exp1.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
